// File: rtl/collatz_pkg.sv
// Shared types and width helpers for the Collatz engine.
// Optional build macro: COLLATZ_SHORTCUT_EN (merges each odd step with the following halving).
package collatz_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  // 3n+1 needs two guard bits above the working width to expose overflow
  localparam int EXT_BITS = 2;

  function automatic int ext_w(input int w);
    return w + EXT_BITS;
  endfunction

  typedef struct packed {
    logic overflow;
    logic sat;
    logic zero_err;
  } flags_t;

endpackage

// File: rtl/collatz_step.sv
// Combinational Collatz successor: n/2 or 3n+1, with guard-bit overflow detection.
// Optional build macro: COLLATZ_SHORTCUT_EN (odd step yields (3n+1)/2 and counts two steps).
module collatz_step
  import collatz_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] next_n,
  output logic [WIDTH-1:0] peak_cand,
  output logic             odd,
  output logic             ovf,
  output logic [1:0]       step_inc
);

  localparam int TW = ext_w(WIDTH);

  logic [TW-1:0] t;

  always_comb begin
    t         = ({2'b00, n} << 1) + {2'b00, n} + TW'(1);
    odd       = n[0];
    ovf       = odd && (t[TW-1:WIDTH] != '0);
    peak_cand = t[WIDTH-1:0];
    next_n    = n >> 1;
    step_inc  = 2'd1;
    if (odd) begin
`ifdef COLLATZ_SHORTCUT_EN
      // 3n+1 of an odd n is always even, so the halving can be folded in
      next_n   = t[WIDTH:1];
      step_inc = 2'd2;
`else
      next_n   = t[WIDTH-1:0];
`endif
    end
  end

endmodule

// File: rtl/collatz_engine.sv
// Collatz sequence engine: FSM, step counter, peak tracker and start/done handshake.
// Optional build macro: COLLATZ_SHORTCUT_EN (selects the two-steps-per-odd-cycle datapath).
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  seed,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps,
  output logic [WIDTH-1:0]  peak,
  output logic              overflow,
  output logic              sat,
  output logic              zero_err
);

  localparam logic [STEP_W-1:0] STEP_MAX = '1;

  state_t           state;
  flags_t           flags;
  logic [WIDTH-1:0] n;

  logic [WIDTH-1:0] next_n;
  logic [WIDTH-1:0] peak_cand;
  logic             odd;
  logic             ovf;
  logic [1:0]       step_inc;

  function automatic logic step_would_sat(input logic [STEP_W-1:0] s, input logic [1:0] inc);
    return ({1'b0, s} + (STEP_W + 1)'(inc)) > {1'b0, STEP_MAX};
  endfunction

  function automatic logic [WIDTH-1:0] max_w(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  collatz_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .n        (n),
    .next_n   (next_n),
    .peak_cand(peak_cand),
    .odd      (odd),
    .ovf      (ovf),
    .step_inc (step_inc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      steps <= '0;
      peak  <= '0;
      flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n     <= seed;
            peak  <= seed;
            steps <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            if (seed == '0) begin
              flags <= '{overflow: 1'b0, sat: 1'b0, zero_err: 1'b1};
              state <= FIN;
              done  <= 1'b1;
            end else begin
              flags <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (n == WIDTH'(1)) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (ovf) begin
            flags.overflow <= 1'b1;
            state          <= FIN;
            done           <= 1'b1;
          end else if (step_would_sat(steps, step_inc)) begin
            flags.sat <= 1'b1;
            state     <= FIN;
            done      <= 1'b1;
          end else begin
            n     <= next_n;
            steps <= steps + STEP_W'(step_inc);
            if (odd) peak <= max_w(peak, peak_cand);
          end
        end
        FIN: begin
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign overflow = flags.overflow;
  assign sat      = flags.sat;
  assign zero_err = flags.zero_err;

endmodule
